// File: rtl/debug_port_master.sv
`default_nettype none
// ============================================================================
// Module   : debug_port_master
// Purpose  : Single-outstanding initiator driving the I-cache/D-cache debug
//            ports (A2/WD2/WE2/RD2) from a valid/ready command channel.
//            Optional macro DEBUG_READBACK_VERIFY_EN re-reads every write.
// Revision : 1.0 - initial release
// ============================================================================
module debug_port_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  err_count,
  output logic        core_hold,
  output logic [31:0] CPU_Debug_InstCache_A2,
  output logic [31:0] CPU_Debug_InstCache_WD2,
  output logic [3:0]  CPU_Debug_InstCache_WE2,
  input  logic [31:0] CPU_Debug_InstCache_RD2,
  output logic [31:0] CPU_Debug_DataCache_A2,
  output logic [31:0] CPU_Debug_DataCache_WD2,
  output logic [3:0]  CPU_Debug_DataCache_WE2,
  input  logic [31:0] CPU_Debug_DataCache_RD2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        core_hold_q, core_hold_d;
  logic [31:0] ic_a2_q, ic_a2_d, ic_wd2_q, ic_wd2_d;
  logic [3:0]  ic_we2_q, ic_we2_d;
  logic [31:0] dc_a2_q, dc_a2_d, dc_wd2_q, dc_wd2_d;
  logic [3:0]  dc_we2_q, dc_we2_d;
  logic        accept;
  logic        err_inc;
  logic [31:0] rd_sel;

`ifdef DEBUG_READBACK_VERIFY_EN
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] be_mask;
  logic        rb_mismatch;

  assign be_mask     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign rb_mismatch = |((rd_sel ^ wdata_q) & be_mask);
`endif

  // cmd_ready_q is only high in IDLE, so it alone qualifies the handshake
  assign accept = cmd_valid && cmd_ready_q;
  assign rd_sel = op_q[0] ? CPU_Debug_DataCache_RD2 : CPU_Debug_InstCache_RD2;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ic_a2_d     = ic_a2_q;
    ic_wd2_d    = ic_wd2_q;
    ic_we2_d    = 4'b0000;
    dc_a2_d     = dc_a2_q;
    dc_wd2_d    = dc_wd2_q;
    dc_we2_d    = 4'b0000;
    err_inc     = 1'b0;
`ifdef DEBUG_READBACK_VERIFY_EN
    wdata_d     = wdata_q;
    be_d        = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = cmd_op;
`ifdef DEBUG_READBACK_VERIFY_EN
          wdata_d = cmd_wdata;
          be_d    = cmd_be;
`endif
          if (cmd_addr[1:0] != 2'b00) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_err_d   = 1'b1;
            err_inc     = 1'b1;
          end else begin
            // Port registers load here so they are visible during ISSUE
            state_d = ISSUE;
            if (cmd_op[0]) begin
              dc_a2_d = cmd_addr;
              if (!cmd_op[1]) begin
                dc_wd2_d = cmd_wdata;
                dc_we2_d = cmd_be;
              end
            end else begin
              ic_a2_d = cmd_addr;
              if (!cmd_op[1]) begin
                ic_wd2_d = cmd_wdata;
                ic_we2_d = cmd_be;
              end
            end
          end
        end
      end
      ISSUE: begin
`ifdef DEBUG_READBACK_VERIFY_EN
        state_d = WAIT;
        cnt_d   = 3'(READ_LATENCY - 1);
`else
        if (op_q[1]) begin
          state_d = WAIT;
          cnt_d   = 3'(READ_LATENCY - 1);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_err_d   = 1'b0;
        end
`endif
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rd_sel;
`ifdef DEBUG_READBACK_VERIFY_EN
          rsp_err_d   = !op_q[1] && rb_mismatch;
          err_inc     = !op_q[1] && rb_mismatch;
`else
          rsp_err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    core_hold_d = (state_d != IDLE);
    err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      cnt_q       <= 3'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'd0;
      core_hold_q <= 1'b0;
      ic_a2_q     <= 32'd0;
      ic_wd2_q    <= 32'd0;
      ic_we2_q    <= 4'b0000;
      dc_a2_q     <= 32'd0;
      dc_wd2_q    <= 32'd0;
      dc_we2_q    <= 4'b0000;
`ifdef DEBUG_READBACK_VERIFY_EN
      wdata_q     <= 32'd0;
      be_q        <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
      core_hold_q <= core_hold_d;
      ic_a2_q     <= ic_a2_d;
      ic_wd2_q    <= ic_wd2_d;
      ic_we2_q    <= ic_we2_d;
      dc_a2_q     <= dc_a2_d;
      dc_wd2_q    <= dc_wd2_d;
      dc_we2_q    <= dc_we2_d;
`ifdef DEBUG_READBACK_VERIFY_EN
      wdata_q     <= wdata_d;
      be_q        <= be_d;
`endif
    end
  end

  assign cmd_ready               = cmd_ready_q;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_data                = rsp_data_q;
  assign rsp_err                 = rsp_err_q;
  assign err_count               = err_count_q;
  assign core_hold               = core_hold_q;
  assign CPU_Debug_InstCache_A2  = ic_a2_q;
  assign CPU_Debug_InstCache_WD2 = ic_wd2_q;
  assign CPU_Debug_InstCache_WE2 = ic_we2_q;
  assign CPU_Debug_DataCache_A2  = dc_a2_q;
  assign CPU_Debug_DataCache_WD2 = dc_wd2_q;
  assign CPU_Debug_DataCache_WE2 = dc_we2_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_port_master
// Purpose  : Randomized self-checking bench for debug_port_master against a
//            per-command reference model; honours DEBUG_READBACK_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_port_master;
  localparam int RL = 2;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic        core_hold;
  logic [31:0] ic_a2, ic_wd2, ic_rd, dc_a2, dc_wd2, dc_rd;
  logic [3:0]  ic_we2, dc_we2;

  int vectors = 0;
  int miscompares = 0;

  always #5 CPU_CLK = ~CPU_CLK;

  debug_port_master #(.READ_LATENCY(RL)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_count(err_count), .core_hold(core_hold),
    .CPU_Debug_InstCache_A2(ic_a2), .CPU_Debug_InstCache_WD2(ic_wd2),
    .CPU_Debug_InstCache_WE2(ic_we2), .CPU_Debug_InstCache_RD2(ic_rd),
    .CPU_Debug_DataCache_A2(dc_a2), .CPU_Debug_DataCache_WD2(dc_wd2),
    .CPU_Debug_DataCache_WE2(dc_we2), .CPU_Debug_DataCache_RD2(dc_rd)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  function automatic logic [31:0] init_word(input logic sel, input int k);
    return {8'(k), 8'(~k), (sel ? 8'h5A : 8'hC3), 8'(k * 3)};
  endfunction

  // Cache environment: write-first memories with an RL-deep read pipeline
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] ipipe [RL];
  logic [31:0] dpipe [RL];
  logic        env_init = 1'b0;
  logic        dovr_en = 1'b0;
  logic [31:0] dovr_val = 32'd0;

  always @(posedge CPU_CLK) begin
    if (env_init) begin
      for (int k = 0; k < 256; k++) begin
        imem[k] <= init_word(1'b0, k);
        dmem[k] <= init_word(1'b1, k);
      end
    end else begin
      if (ic_we2 != 4'd0) imem[ic_a2[9:2]] <= merge(imem[ic_a2[9:2]], ic_wd2, ic_we2);
      if (dc_we2 != 4'd0) dmem[dc_a2[9:2]] <= merge(dmem[dc_a2[9:2]], dc_wd2, dc_we2);
    end
    ipipe[0] <= merge(imem[ic_a2[9:2]], ic_wd2, ic_we2);
    dpipe[0] <= merge(dmem[dc_a2[9:2]], dc_wd2, dc_we2);
    for (int k = 1; k < RL; k++) begin
      ipipe[k] <= ipipe[k-1];
      dpipe[k] <= dpipe[k-1];
    end
  end

  assign ic_rd = ipipe[RL-1];
  assign dc_rd = dovr_en ? dovr_val : dpipe[RL-1];

  // Reference model: per-command results from the block's rules
  logic [31:0] ref_imem [256];
  logic [31:0] ref_dmem [256];
  int          exp_errcnt = 0;
  logic [31:0] exp_data;
  logic        exp_err;
  int          exp_lat;

  task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int idx;
    logic [31:0] m;
    idx = int'(addr[9:2]);
    if (addr[1:0] != 2'b00) begin
      exp_data = 32'd0; exp_err = 1'b1; exp_lat = 1;
      if (exp_errcnt < 255) exp_errcnt++;
    end else if (!op[1]) begin
      m = merge(op[0] ? ref_dmem[idx] : ref_imem[idx], wd, be);
      if (op[0]) ref_dmem[idx] = m; else ref_imem[idx] = m;
`ifdef DEBUG_READBACK_VERIFY_EN
      exp_data = m; exp_err = 1'b0; exp_lat = 2 + RL;
`else
      exp_data = 32'd0; exp_err = 1'b0; exp_lat = 2;
`endif
    end else begin
      exp_data = op[0] ? ref_dmem[idx] : ref_imem[idx];
      exp_err = 1'b0; exp_lat = 2 + RL;
    end
  endtask

  // Observations from the most recent transaction
  logic [31:0] obs_data;
  logic        obs_err;
  int          obs_lat, obs_wait, obs_wecnt_i, obs_wecnt_d, obs_hold_bad, obs_stall_bad;
  logic [3:0]  obs_we1_i, obs_we1_d;

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int stall);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_be = be; cmd_valid = 1'b1;
    obs_wait = 0;
    while (!cmd_ready && obs_wait < 50) begin step(); obs_wait++; end
    if (obs_wait >= 50) begin
      vectors++; miscompares++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, obs_wait);
    end
    step();
    cmd_valid = 1'b0;
    obs_we1_i = ic_we2; obs_we1_d = dc_we2;
    obs_wecnt_i = 0; obs_wecnt_d = 0; obs_hold_bad = 0; obs_stall_bad = 0;
    obs_lat = 1;
    while (!rsp_valid && obs_lat < 50) begin
      if (ic_we2 != 4'd0) obs_wecnt_i++;
      if (dc_we2 != 4'd0) obs_wecnt_d++;
      if (!core_hold) obs_hold_bad++;
      step();
      obs_lat++;
    end
    if (obs_lat >= 50) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, obs_lat);
    end
    obs_data = rsp_data; obs_err = rsp_err;
    for (int k = 0; k < stall; k++) begin
      step();
      if (!rsp_valid || rsp_data !== obs_data || rsp_err !== obs_err || cmd_ready || !core_hold)
        obs_stall_bad++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    CPU_RST = 1'b1; env_init = 1'b1;
    step(); step();
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
    vectors++;
    if ({rsp_valid, rsp_err, core_hold} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: valid/err/hold got %b want 000", {rsp_valid, rsp_err, core_hold});
    end
    vectors++;
    if (rsp_data !== 32'd0 || err_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_data: rsp_data=%h err_count=%0d want 0/0", rsp_data, err_count);
    end
    vectors++;
    if ({ic_a2, ic_wd2, ic_we2, dc_a2, dc_wd2, dc_we2} !== 136'd0) begin
      miscompares++; $display("FAIL reset_ports: ic_a2=%h ic_we2=%b dc_a2=%h dc_we2=%b want all 0", ic_a2, ic_we2, dc_a2, dc_we2);
    end
    for (int k = 0; k < 256; k++) begin
      ref_imem[k] = init_word(1'b0, k);
      ref_dmem[k] = init_word(1'b1, k);
    end
    exp_errcnt = 0;
    env_init = 1'b0; CPU_RST = 1'b0;
    step();
    vectors++;
    if (cmd_ready !== 1'b1 || core_hold !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: cmd_ready=%0b core_hold=%0b want 1/0", cmd_ready, core_hold);
    end
  endtask

  task automatic test_write();
    model(2'b00, 32'h0000_0010, 32'h0000_0013, 4'hF);
    run_cmd(2'b00, 32'h0000_0010, 32'h0000_0013, 4'hF, 0);
    vectors++;
    if (obs_lat != exp_lat) begin miscompares++; $display("FAIL write_latency: got %0d want %0d", obs_lat, exp_lat); end
    vectors++;
    if (obs_err !== exp_err || obs_data !== exp_data) begin
      miscompares++; $display("FAIL write_rsp: err=%0b data=%h want %0b/%h", obs_err, obs_data, exp_err, exp_data);
    end
    vectors++;
    if (obs_we1_i !== 4'hF || obs_wecnt_i != 1) begin
      miscompares++; $display("FAIL write_ic_we2: first=%b cycles=%0d want 1111/1", obs_we1_i, obs_wecnt_i);
    end
    vectors++;
    if (obs_we1_d !== 4'h0 || obs_wecnt_d != 0) begin
      miscompares++; $display("FAIL write_dc_idle: first=%b cycles=%0d want 0000/0", obs_we1_d, obs_wecnt_d);
    end
    vectors++;
    if (ic_a2 !== 32'h10 || ic_wd2 !== 32'h13) begin
      miscompares++; $display("FAIL write_ic_hold: a2=%h wd2=%h want 00000010/00000013", ic_a2, ic_wd2);
    end
    model(2'b01, 32'h0000_0040, 32'hCAFE_F00D, 4'h0);
    run_cmd(2'b01, 32'h0000_0040, 32'hCAFE_F00D, 4'h0, 0);
    vectors++;
    if (obs_lat != exp_lat || obs_err !== 1'b0 || obs_data !== exp_data) begin
      miscompares++; $display("FAIL zero_be_write: lat=%0d err=%0b data=%h want %0d/0/%h", obs_lat, obs_err, obs_data, exp_lat, exp_data);
    end
    vectors++;
    if (obs_wecnt_d != 0 || dc_a2 !== 32'h40) begin
      miscompares++; $display("FAIL zero_be_ports: we_cycles=%0d a2=%h want 0/00000040", obs_wecnt_d, dc_a2);
    end
  endtask

  task automatic test_read();
    model(2'b01, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
    run_cmd(2'b01, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 0);
    model(2'b11, 32'h0000_0020, 32'd0, 4'h0);
    run_cmd(2'b11, 32'h0000_0020, 32'd0, 4'h0, 0);
    vectors++;
    if (obs_data !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin
      miscompares++; $display("FAIL read_data: data=%h err=%0b want deadbeef/0", obs_data, obs_err);
    end
    vectors++;
    if (obs_lat != 2 + RL) begin miscompares++; $display("FAIL read_latency: got %0d want %0d", obs_lat, 2 + RL); end
    vectors++;
    if (obs_hold_bad != 0 || obs_wecnt_i != 0 || obs_wecnt_d != 0) begin
      miscompares++; $display("FAIL read_hold_we: hold_low=%0d ic_we=%0d dc_we=%0d want 0/0/0", obs_hold_bad, obs_wecnt_i, obs_wecnt_d);
    end
    vectors++;
    if (core_hold !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL read_release: core_hold=%0b cmd_ready=%0b want 0/1", core_hold, cmd_ready);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] a_i, a_d, rnd;
    int bad;
    a_i = ic_a2; a_d = dc_a2;
    model(2'b11, 32'h0000_0022, 32'd0, 4'h0);
    run_cmd(2'b11, 32'h0000_0022, 32'd0, 4'h0, 0);
    vectors++;
    if (obs_lat != 1 || obs_err !== 1'b1 || obs_data !== 32'd0) begin
      miscompares++; $display("FAIL misaligned_rsp: lat=%0d err=%0b data=%h want 1/1/0", obs_lat, obs_err, obs_data);
    end
    vectors++;
    if (obs_we1_i !== 4'd0 || obs_we1_d !== 4'd0 || ic_a2 !== a_i || dc_a2 !== a_d) begin
      miscompares++; $display("FAIL misaligned_ports: ic_we=%b dc_we=%b ic_a2=%h dc_a2=%h want idle", obs_we1_i, obs_we1_d, ic_a2, dc_a2);
    end
    vectors++;
    if (err_count !== 8'd1) begin miscompares++; $display("FAIL misaligned_count: got %0d want 1", err_count); end
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      rnd = $urandom();
      rnd[1:0] = 2'($urandom_range(1, 3));
      model(2'(n), rnd, 32'd0, 4'hF);
      run_cmd(2'(n), rnd, 32'd0, 4'hF, 0);
      if (obs_err !== 1'b1 || obs_lat != 1) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL misaligned_burst: %0d bad responses want 0", bad); end
    vectors++;
    if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_count_saturate: got %0d want 255", err_count); end
  endtask

  task automatic test_stall();
    logic [31:0] w, d0;
    logic        e0;
    int          n, bad;
    w = $urandom();
    model(2'b01, 32'h0000_0080, w, 4'hF);
    cmd_op = 2'b01; cmd_addr = 32'h80; cmd_wdata = w; cmd_be = 4'hF; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    step();
    cmd_op = 2'b11; cmd_wdata = 32'd0; cmd_be = 4'h0;
    bad = 0; n = 1;
    while (!rsp_valid && n < 50) begin if (cmd_ready) bad++; step(); n++; end
    vectors++;
    if (n != exp_lat) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", n, exp_lat); end
    d0 = rsp_data; e0 = rsp_err;
    vectors++;
    if (d0 !== exp_data || e0 !== exp_err) begin
      miscompares++; $display("FAIL stall_rsp: data=%h err=%0b want %h/%0b", d0, e0, exp_data, exp_err);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL stall_stable: %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_release: cmd_ready=%0b rsp_valid=%0b want 1/0", cmd_ready, rsp_valid);
    end
    model(2'b11, 32'h0000_0080, 32'd0, 4'h0);
    run_cmd(2'b11, 32'h0000_0080, 32'd0, 4'h0, 0);
    vectors++;
    if (obs_wait != 0 || obs_data !== exp_data || obs_lat != exp_lat) begin
      miscompares++; $display("FAIL second_cmd: wait=%0d data=%h lat=%0d want 0/%h/%0d", obs_wait, obs_data, obs_lat, exp_data, exp_lat);
    end
  endtask

  task automatic test_abort();
    int n, bad;
    cmd_op = 2'b10; cmd_addr = 32'h0000_0104; cmd_wdata = 32'd0; cmd_be = 4'h0; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    step();
    cmd_valid = 1'b0;
    step();
    CPU_RST = 1'b1;
    step();
    vectors++;
    if (rsp_valid !== 1'b0 || ic_we2 !== 4'd0 || dc_we2 !== 4'd0) begin
      miscompares++; $display("FAIL abort_outputs: rsp_valid=%0b ic_we=%b dc_we=%b want 0", rsp_valid, ic_we2, dc_we2);
    end
    vectors++;
    if (err_count !== 8'd0 || core_hold !== 1'b0) begin
      miscompares++; $display("FAIL abort_state: err_count=%0d core_hold=%0b want 0/0", err_count, core_hold);
    end
    CPU_RST = 1'b0;
    exp_errcnt = 0;
    rsp_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin step(); if (rsp_valid) bad++; end
    rsp_ready = 1'b0;
    vectors++;
    if (bad != 0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL abort_no_rsp: rsp cycles=%0d cmd_ready=%0b want 0/1", bad, cmd_ready);
    end
  endtask

`ifdef DEBUG_READBACK_VERIFY_EN
  task automatic test_verify();
    model(2'b01, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    dovr_en = 1'b1; dovr_val = 32'hFFFF_5678;
    run_cmd(2'b01, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0);
    vectors++;
    if (obs_err !== 1'b0 || obs_data !== 32'hFFFF_5678 || obs_lat != 2 + RL) begin
      miscompares++; $display("FAIL verify_match: err=%0b data=%h lat=%0d want 0/ffff5678/%0d", obs_err, obs_data, obs_lat, 2 + RL);
    end
    model(2'b01, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    dovr_val = 32'h1234_0078;
    run_cmd(2'b01, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0);
    dovr_en = 1'b0;
    if (exp_errcnt < 255) exp_errcnt++;
    vectors++;
    if (obs_err !== 1'b1 || obs_data !== 32'h1234_0078) begin
      miscompares++; $display("FAIL verify_mismatch: err=%0b data=%h want 1/12340078", obs_err, obs_data);
    end
    vectors++;
    if (err_count !== 8'(exp_errcnt)) begin
      miscompares++; $display("FAIL verify_count: got %0d want %0d", err_count, exp_errcnt);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] addr, wd;
    logic [3:0]  be, ew_i, ew_d;
    int          stall;
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom_range(0, 3));
      addr = $urandom();
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      wd = $urandom();
      be = 4'($urandom_range(0, 15));
      stall = $urandom_range(0, 3);
      ew_i = (addr[1:0] == 2'b00 && op == 2'b00) ? be : 4'd0;
      ew_d = (addr[1:0] == 2'b00 && op == 2'b01) ? be : 4'd0;
      model(op, addr, wd, be);
      run_cmd(op, addr, wd, be, stall);
      vectors++;
      if (obs_data !== exp_data || obs_err !== exp_err) begin
        miscompares++; $display("FAIL rand_rsp[%0d]: op=%0d addr=%h data=%h err=%0b want %h/%0b", n, op, addr, obs_data, obs_err, exp_data, exp_err);
      end
      vectors++;
      if (obs_lat != exp_lat || obs_wait != 0) begin
        miscompares++; $display("FAIL rand_timing[%0d]: lat=%0d wait=%0d want %0d/0", n, obs_lat, obs_wait, exp_lat);
      end
      vectors++;
      if (obs_we1_i !== ew_i || obs_we1_d !== ew_d) begin
        miscompares++; $display("FAIL rand_we2[%0d]: ic=%b dc=%b want %b/%b", n, obs_we1_i, obs_we1_d, ew_i, ew_d);
      end
      vectors++;
      if (err_count !== 8'(exp_errcnt) || obs_stall_bad != 0) begin
        miscompares++; $display("FAIL rand_count[%0d]: err_count=%0d stall_bad=%0d want %0d/0", n, err_count, obs_stall_bad, exp_errcnt);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_misaligned();
    test_stall();
    test_abort();
`ifdef DEBUG_READBACK_VERIFY_EN
    test_verify();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_port_master.md
# debug_port_master

Host-side initiator for the core's cache debug ports: accepts single-word read/write commands on a valid/ready command channel, drives the instruction-cache and data-cache debug ports (A2/WD2/WE2), samples RD2 and returns one response per command on a valid/ready response channel. It sits between the board-level loader or host link and the core's debug inputs. It is used to preload programs into the instruction cache and to dump data-cache contents after a run. It also holds the core idle while a debug access is in flight.

## Interface

Parameters:
- READ_LATENCY, 1, cycles from A2 driven (ISSUE cycle) to RD2 valid; legal range 1..7.

Ports:
- CPU_CLK  in  1  sole clock; everything is rising-edge.
- CPU_RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 write inst, 01 write data, 10 read inst, 11 read data.
- cmd_addr  in  32  byte address; must be word-aligned.
- cmd_wdata  in  32  write data.
- cmd_be  in  4  byte-lane write enables (writes only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  read data / readback data.
- rsp_err  out  1  misaligned address or readback mismatch.
- err_count  out  8  saturating error counter.
- core_hold  out  1  high while a command is in flight.
- CPU_Debug_InstCache_A2 / _WD2  out  32 each  inst-cache debug address / write data.
- CPU_Debug_InstCache_WE2  out  4  inst-cache debug byte write enable.
- CPU_Debug_InstCache_RD2  in  32  inst-cache debug read data.
- CPU_Debug_DataCache_A2 / _WD2 / _WE2 / _RD2: same as above, for the data cache.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/addr/wdata/be and go to ISSUE.
  - Exception: if cmd_addr[1:0]!=0, go straight to RESP with rsp_err=1, rsp_data=0 and no port activity.
- ISSUE (exactly one cycle): the selected cache's A2=addr.
  - Writes: WD2=wdata and WE2=be. Next state is RESP, or WAIT when readback verification is compiled in.
  - Reads: WE2=0 and A2=addr. Next state is WAIT.
- WAIT: a 3-bit counter loads READ_LATENCY-1 on entry to WAIT and decrements.
  - At 0: capture the selected RD2 into rsp_data and go to RESP.
  - A2 is held at addr; WE2=0 throughout.
- RESP: rsp_valid=1, with rsp_data/rsp_err held stable. On rsp_ready, go to IDLE.
- Write responses without verification carry rsp_data=0, rsp_err=0.
- The non-selected cache's ports stay idle: WE2=0, A2/WD2 unchanged.
- Outside ISSUE both WE2 are 0. A2/WD2 hold their last driven value.
- err_count increments by 1 on each response with rsp_err=1 and saturates at 255.
- core_hold=1 whenever state!=IDLE.
- A zero cmd_be write still issues a cycle with WE2=0000 and returns a normal ack.

## Timing

- Reset values: cmd_ready=0 during the reset cycle and 1 from the cycle after reset (IDLE).
  - All other outputs (rsp_valid, rsp_data, rsp_err, err_count, core_hold, all A2/WD2/WE2) reset to 0.
- All outputs are registered; there is no combinational path from cmd_* or RD2 to outputs.
- Write latency: accept edge T; ISSUE in cycle T+1; rsp_valid high from cycle T+2.
- Read latency: rsp_valid high from cycle T+2+READ_LATENCY.
- Misaligned command: rsp_valid high from cycle T+1.
- Throughput: one command in flight; the next accept happens at the earliest in the cycle after the rsp handshake.
- CPU_RST asserted in any state: IDLE on the next edge. WE2 is cleared at that same edge, and any pending response is discarded (rsp_valid=0).
- If rsp_ready is held low, the FSM stalls in RESP indefinitely with outputs stable.

## Configuration

- DEBUG_READBACK_VERIFY_EN defined: every write goes ISSUE -> WAIT, re-reading the same address with WE2=0.
  - The captured RD2 is compared with wdata on the byte lanes enabled by be.
  - Mismatch: rsp_err=1 and err_count++. rsp_data = the readback word in both cases.
  - Write latency becomes 2+READ_LATENCY.
- Not defined: writes go ISSUE -> RESP with rsp_data=0, and the compare logic is absent.

## Test plan

- Reset, then write inst, addr 0x0000_0010, data 0x0000_0013, be 1111 -> InstCache_WE2=1111 for exactly one cycle at T+1, DataCache_WE2 stays 0, rsp_valid at T+2 with rsp_err=0.
- Read data at 0x0000_0020 with a memory model returning 0xDEAD_BEEF, READ_LATENCY=2 -> rsp_data=0xDEAD_BEEF, rsp_valid at T+4, core_hold high T+1..handshake.
- Command at addr 0x0000_0022 -> no WE2/A2 change, rsp_err=1, err_count 0->1; 300 misaligned commands -> err_count=255.
- Hold rsp_ready=0 for 10 cycles, with cmd_valid held high carrying a second command -> rsp stable, cmd_ready=0, second command accepted only after the handshake.
- Assert CPU_RST during WAIT -> next cycle: IDLE, rsp_valid=0, all WE2=0, err_count=0; no response is ever delivered for the aborted command.
- With DEBUG_READBACK_VERIFY_EN, write 0x1234_5678 be 0011, model returns 0xFFFF_5678 -> rsp_err=0; model returns 0x1234_0078 -> rsp_err=1, rsp_data=0x1234_0078.
